// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DBIT data bits (LSB first), SB_TICK/16 stop bits.
// Bit timing is derived from a 16x oversampling baud tick (s_tick).
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic            s_tick,
    input  logic [DBIT-1:0] tx_data,
    output logic            tx,
    output logic            tx_done_tick,
    output logic            busy
);

    // Tick counter must reach both 15 (one bit period) and SB_TICK-1 (stop period).
    localparam int S_MAX = (SB_TICK > 16) ? SB_TICK - 1 : 15;
    localparam int SW    = $clog2(S_MAX + 1);
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;
    logic [DBIT-1:0] b_shift;

    // Next data bit presented on the line once the current one has been sent.
    always_comb begin
        b_shift = b >> 1;
    end

    // Frame sequencer with registered line, done pulse and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
            busy         <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        b     <= tx_data;
                        s     <= '0;
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == S_BIT_LAST) begin
                            s     <= '0;
                            n     <= '0;
                            state <= DATA;
                            tx    <= b[0];
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == S_BIT_LAST) begin
                            s <= '0;
                            b <= b_shift;
                            if (n == N_LAST) begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end else begin
                                n  <= n + 1'b1;
                                tx <= b_shift[0];
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == S_STOP_LAST) begin
                            state        <= IDLE;
                            tx_done_tick <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (1 and 2 stop bits) share stimulus;
// a tick-indexed frame model predicts line, busy and done every cycle.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_start = 1'b0;
    logic       s_tick = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx0, done0, busy0;
    logic       tx1, done1, busy1;

    uart_tx #(.DBIT(8), .SB_TICK(16)) u0 (
        .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick),
        .tx_data(tx_data), .tx(tx0), .tx_done_tick(done0), .busy(busy0)
    );

    uart_tx #(.DBIT(8), .SB_TICK(32)) u1 (
        .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick),
        .tx_data(tx_data), .tx(tx1), .tx_done_tick(done1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level j ticks after acceptance (j < frame total).
    function automatic logic line_at(input int j, input logic [7:0] d);
        if (j < 16) return 1'b0;
        if (j < 16 + 16 * 8) return d[(j - 16) / 16];
        return 1'b1;
    endfunction

    // Reference model state, one slot per instance.
    int         total[2] = '{160, 176};
    bit         act[2];
    int         tj[2];
    logic [7:0] md[2];
    int         acc[2];
    bit         edone[2];
    int         exp_dn[2];
    int         dut_dn[2];
    int         last_lat[2];
    int         last_done[2];
    int         cyc = 0;
    bit         armed = 1'b0;
    logic       r_s, st_s, tk_s;
    logic [7:0] d_s;
    logic       gtx, gbusy, gdone;

    always @(posedge clk) begin
        r_s = reset; st_s = tx_start; tk_s = s_tick; d_s = tx_data;
        cyc++;
        if (r_s) armed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            edone[i] = 1'b0;
            if (r_s) begin
                act[i] = 1'b0;
            end else if (!act[i]) begin
                if (st_s) begin
                    act[i] = 1'b1; tj[i] = 0; md[i] = d_s; acc[i] = cyc;
                end
            end else if (tk_s) begin
                tj[i]++;
                if (tj[i] == total[i]) begin
                    act[i] = 1'b0; edone[i] = 1'b1; exp_dn[i]++;
                end
            end
        end
        #1;
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                gtx   = (i == 0) ? tx0 : tx1;
                gbusy = (i == 0) ? busy0 : busy1;
                gdone = (i == 0) ? done0 : done1;
                check($sformatf("tx%0d@%0d", i, cyc), 32'(gtx),
                      32'(act[i] ? line_at(tj[i], md[i]) : 1'b1));
                check($sformatf("busy%0d@%0d", i, cyc), 32'(gbusy), 32'(act[i]));
                check($sformatf("done%0d@%0d", i, cyc), 32'(gdone), 32'(edone[i]));
                if (gdone === 1'b1) begin
                    dut_dn[i]++;
                    last_lat[i]  = cyc - acc[i];
                    last_done[i] = cyc;
                end
            end
        end
    end

    // Stimulus: all input changes happen at the falling edge.
    int period = 1;
    int tcnt = 0;

    task automatic step();
        @(negedge clk);
        tcnt++;
        if (tcnt >= period) begin
            tcnt = 0; s_tick = 1'b1;
        end else begin
            s_tick = 1'b0;
        end
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Request a frame now; first s_tick lands 'period' cycles after acceptance.
    task automatic send(input logic [7:0] d);
        tx_start = 1'b1; tx_data = d; tcnt = 0; s_tick = 1'b0;
        step();
        tx_start = 1'b0; tx_data = 8'($urandom);
    endtask

    task automatic wait_done(input int i);
        int k = 0;
        do begin
            step(); k++;
        end while (!((i == 0) ? done0 : done1) && k < 5000);
        if (k >= 5000) check($sformatf("timeout%0d", i), 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy0 || busy1) && k < 5000) begin
            step(); k++;
        end
        if (k >= 5000) check("idle_timeout", 32'd0, 32'd1);
    endtask

    int prev_done;

    initial begin
        step();
        // Reset held with tx_start high: nothing may start.
        reset = 1'b1; tx_start = 1'b1; tx_data = 8'hFF;
        steps(3);
        reset = 1'b0; tx_start = 1'b0;
        steps(3);
        check("reset_no_done", 32'(dut_dn[0] + dut_dn[1]), 32'd0);

        // Single frame, tick every clock.
        period = 1;
        send(8'hA5);
        wait_done(0);
        check("a5_lat", 32'(last_lat[0]), 32'd160);
        wait_done(1);
        check("a5_lat_sb32", 32'(last_lat[1]), 32'd176);
        steps(4);

        // Slow tick: one tick every 4 clocks.
        period = 4;
        send(8'h01);
        wait_done(0);
        check("slow_lat", 32'(last_lat[0]), 32'd640);
        wait_idle();
        steps(4);

        // tx_start during DATA is ignored.
        period = 1;
        send(8'h00);
        steps(40);
        tx_start = 1'b1; tx_data = 8'hFF;
        step();
        tx_start = 1'b0;
        wait_done(0);
        check("ignored_lat", 32'(last_lat[0]), 32'd160);
        wait_idle();
        check("ignored_cnt", 32'(dut_dn[0]), 32'(exp_dn[0]));

        // Back-to-back: new request in the done cycle.
        send(8'h96);
        wait_done(0);
        prev_done = last_done[0];
        send(8'h3C);
        check("b2b_gap", 32'(acc[0] - prev_done), 32'd1);
        wait_done(0);
        check("b2b_lat", 32'(last_lat[0]), 32'd160);
        wait_idle();

        // Reset in data bit 4 aborts, then a clean 0x5A frame.
        send(8'($urandom));
        steps(16 + 16 * 4 + 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        steps(5);
        check("abort_cnt0", 32'(dut_dn[0]), 32'(exp_dn[0]));
        check("abort_cnt1", 32'(dut_dn[1]), 32'(exp_dn[1]));
        send(8'h5A);
        wait_done(0);
        check("post_abort_lat", 32'(last_lat[0]), 32'd160);
        wait_idle();

        // Randomized frames with random tick rate and stray requests.
        for (int f = 0; f < 6; f++) begin
            period = 1 + int'($urandom_range(0, 2));
            send(8'($urandom));
            for (int c = 0; c < 100; c++) begin
                step();
                if ($urandom_range(0, 15) == 0) begin
                    tx_start = 1'b1; tx_data = 8'($urandom);
                    step();
                    tx_start = 1'b0;
                end
            end
            wait_idle();
            steps(int'($urandom_range(0, 5)));
        end

        steps(3);
        check("done_cnt0", 32'(dut_dn[0]), 32'(exp_dn[0]));
        check("done_cnt1", 32'(dut_dn[1]), 32'(exp_dn[1]));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
